// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg
//   Shared definitions for the pipelined immediate generator:
//     INSTR_W   - instruction word width (always 32, also for RV64)
//     imm_sel_e - 3-bit immediate format select
package imm_gen_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_ZERO = 3'b101,
    IMM_ZIMM = 3'b110,
    IMM_ILL  = 3'b111
  } imm_sel_e;

endpackage

// File: rtl/imm_decode.sv
// imm_decode
//   Purely combinational immediate decoder. Builds the 32-bit immediate for
//   the selected format and sign-extends it to XLEN.
//   Optional feature macro: IMM_GEN_ZIMM_EN (sel 110 -> zero-extended CSR
//   zimm instr[19:15]); without it sel 110 is reported as illegal.
// Ports:
//   instr  in   32    instruction word
//   sel    in   3     immediate format select (imm_sel_e encoding)
//   imm    out  XLEN  extended immediate
//   err    out  1     illegal select
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  input  logic [2:0]         sel,
  output logic [XLEN-1:0]    imm,
  output logic               err
);

  // Immediate at 32 bits, already sign-extended within the word; widening to
  // XLEN is then a plain signed cast (zimm has bit 31 clear, so it stays
  // zero-extended).
  logic [INSTR_W-1:0] raw;

  // The opcode field never contributes to any immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    raw = '0;
    err = 1'b0;
    case (imm_sel_e'(sel))
      IMM_I:    raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:    raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:    raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                       instr[11:8], 1'b0};
      IMM_U:    raw = {instr[31:12], 12'b0};
      IMM_J:    raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                       instr[30:21], 1'b0};
      IMM_ZERO: raw = '0;
`ifdef IMM_GEN_ZIMM_EN
      IMM_ZIMM: raw = {27'b0, instr[19:15]};
`else
      IMM_ZIMM: err = 1'b1;
`endif
      default:  err = 1'b1;
    endcase
  end

  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Pipelined immediate generator: decodes the immediate on the input side
//   and holds results in an output register (main) backed by one skid entry,
//   giving full throughput under backpressure with a registered in_ready.
//   Optional feature macro: IMM_GEN_ZIMM_EN (see imm_decode).
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      upstream has an instruction
//   in_ready   out  1      block can accept this cycle
//   in_instr   in   32     instruction word
//   in_sel     in   3      immediate format select
//   in_tag     in   TAG_W  pass-through tag
//   out_valid  out  1      result available
//   out_ready  in   1      downstream accepts
//   out_imm    out  XLEN   extended immediate
//   out_tag    out  TAG_W  tag of out_imm
//   out_err    out  1      illegal select for this result
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [2:0]         in_sel,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_imm,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_err
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr (in_instr),
    .sel   (in_sel),
    .imm   (dec_imm),
    .err   (dec_err)
  );

  logic             main_valid_reg, main_valid_next;
  logic [XLEN-1:0]  main_imm_reg,   main_imm_next;
  logic [TAG_W-1:0] main_tag_reg,   main_tag_next;
  logic             main_err_reg,   main_err_next;
  logic             skid_valid_reg, skid_valid_next;
  logic [XLEN-1:0]  skid_imm_reg,   skid_imm_next;
  logic [TAG_W-1:0] skid_tag_reg,   skid_tag_next;
  logic             skid_err_reg,   skid_err_next;

  logic accept;
  logic drain;

  // in_ready comes straight from a flop, so it never depends on out_ready.
  assign in_ready  = !skid_valid_reg;
  assign accept    = in_valid && in_ready;
  assign drain     = main_valid_reg && out_ready;

  assign out_valid = main_valid_reg;
  assign out_imm   = main_imm_reg;
  assign out_tag   = main_tag_reg;
  assign out_err   = main_err_reg;

  always_comb begin
    main_valid_next = main_valid_reg;
    main_imm_next   = main_imm_reg;
    main_tag_next   = main_tag_reg;
    main_err_next   = main_err_reg;
    skid_valid_next = skid_valid_reg;
    skid_imm_next   = skid_imm_reg;
    skid_tag_next   = skid_tag_reg;
    skid_err_next   = skid_err_reg;

    if (drain) begin
      if (skid_valid_reg) begin
        // Older skid entry moves up; no accept is possible this cycle
        // because in_ready is low while skid is occupied.
        main_imm_next   = skid_imm_reg;
        main_tag_next   = skid_tag_reg;
        main_err_next   = skid_err_reg;
        skid_valid_next = 1'b0;
      end else if (accept) begin
        // Drain and refill in the same cycle keeps out_valid high.
        main_imm_next   = dec_imm;
        main_tag_next   = in_tag;
        main_err_next   = dec_err;
      end else begin
        main_valid_next = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_reg) begin
        main_valid_next = 1'b1;
        main_imm_next   = dec_imm;
        main_tag_next   = in_tag;
        main_err_next   = dec_err;
      end else begin
        // Main is stalled: park the new result behind it.
        skid_valid_next = 1'b1;
        skid_imm_next   = dec_imm;
        skid_tag_next   = in_tag;
        skid_err_next   = dec_err;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_reg <= 1'b0;
      main_imm_reg   <= '0;
      main_tag_reg   <= '0;
      main_err_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_imm_reg   <= '0;
      skid_tag_reg   <= '0;
      skid_err_reg   <= 1'b0;
    end else begin
      main_valid_reg <= main_valid_next;
      main_imm_reg   <= main_imm_next;
      main_tag_reg   <= main_tag_next;
      main_err_reg   <= main_err_next;
      skid_valid_reg <= skid_valid_next;
      skid_imm_reg   <= skid_imm_next;
      skid_tag_reg   <= skid_tag_next;
      skid_err_reg   <= skid_err_next;
    end
  end

endmodule
